// File: rtl/speaker_envelope_if.sv
// Signal bundle between the tune-generator side and the amplifier-facing envelope stage.
interface speaker_envelope_if #(
  parameter int PWM_BITS = 4
);
  logic                enable_in;
  logic                tone_in;
  logic [PWM_BITS-1:0] volume_in;
  logic                mute_in;
  logic                speaker_out;
  logic                amp_sd_n;
  logic [PWM_BITS-1:0] level_out;
  logic [1:0]          state_out;

  modport master (
    output enable_in, tone_in, volume_in, mute_in,
    input  speaker_out, amp_sd_n, level_out, state_out
  );

  modport slave (
    input  enable_in, tone_in, volume_in, mute_in,
    output speaker_out, amp_sd_n, level_out, state_out
  );
endinterface

// File: rtl/speaker_envelope.sv
// PWM volume gating of the tune square wave with click-free level ramps and
// amplifier shutdown sequencing (warm-up before audio, full fade before shutdown).
module speaker_envelope #(
  parameter int PWM_BITS      = 4,
  parameter int RAMP_CYCLES   = 4096,
  parameter int WARMUP_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  speaker_envelope_if.slave bus
);
  // state  | meaning
  // OFF    | amp shut down, level 0, counters cleared
  // WARM   | amp enabled, level held at 0 while the amp settles
  // ACTIVE | level ramps toward the target volume
  // DRAIN  | music stopped, level ramps to 0 before shutdown

  localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = LEVEL_MAX - 1'b1;
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
  localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARM   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                tone_q;
  logic                spk_q, spk_d;
  logic                amp_q, amp_d;

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] goal;
  logic [RAMP_W-1:0]   ramp_next;
  logic                ramp_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      level_q <= '0;
      pwm_q   <= '0;
      ramp_q  <= '0;
      warm_q  <= '0;
      tone_q  <= 1'b0;
      spk_q   <= 1'b0;
      amp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
      ramp_q  <= ramp_d;
      warm_q  <= warm_d;
      tone_q  <= bus.tone_in;
      spk_q   <= spk_d;
      amp_q   <= amp_d;
    end
  end

  always_comb begin
    target    = (bus.enable_in && !bus.mute_in) ? bus.volume_in : '0;
    goal      = target;
    ramp_tc   = (ramp_q == RAMP_LAST);
    ramp_next = ramp_tc ? '0 : ramp_q + 1'b1;
    state_d   = state_q;
    level_d   = level_q;
    ramp_d    = '0;
    warm_d    = '0;
    pwm_d     = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;

    case (state_q)
      ST_OFF: begin
        pwm_d   = '0;
        level_d = '0;
        if (bus.enable_in) begin
          state_d = ST_WARM;
          warm_d  = WARM_LAST;
        end
      end
      ST_WARM: begin
        // warm timer is a down-counter loaded on entry; terminal count is 0
        if (!bus.enable_in) begin
          state_d = ST_OFF;
        end else if (warm_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          warm_d = warm_q - 1'b1;
        end
      end
      ST_ACTIVE: begin
        ramp_d = ramp_next;
        if (!bus.enable_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        goal   = '0;
        ramp_d = ramp_next;
        if (bus.enable_in)        state_d = ST_ACTIVE;
        else if (level_q == '0)   state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    // step is taken from the current state even when the state changes on this edge
    if ((state_q == ST_ACTIVE || state_q == ST_DRAIN) && ramp_tc) begin
      if (goal > level_q)      level_d = level_q + 1'b1;
      else if (goal < level_q) level_d = level_q - 1'b1;
    end

    spk_d = tone_q & (pwm_q < level_q) & (state_q != ST_OFF);
    amp_d = (state_d != ST_OFF);
  end

  assign bus.speaker_out = spk_q;
  assign bus.amp_sd_n    = amp_q;
  assign bus.level_out   = level_q;
  assign bus.state_out   = state_q;
endmodule

// File: tb/tb_speaker_envelope.sv
// Directed and randomized bench for speaker_envelope against a cycle-level
// behavioural model built from the envelope's ramp, PWM and sequencing rules.
module tb_speaker_envelope;
  localparam int PWM_BITS = 4;
  localparam int RAMP     = 4;
  localparam int WARM     = 8;
  localparam int PERIOD   = (1 << PWM_BITS) - 1;
  localparam int S_OFF = 0, S_WRM = 1, S_ACT = 2, S_DRN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  speaker_envelope_if #(.PWM_BITS(PWM_BITS)) bus ();

  speaker_envelope #(
    .PWM_BITS(PWM_BITS),
    .RAMP_CYCLES(RAMP),
    .WARMUP_CYCLES(WARM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int m_state, m_level, m_pwm, m_ramp, m_warm, m_tone, m_spk, m_amp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_OFF; m_level = 0; m_pwm = 0; m_ramp = 0;
    m_warm = 0; m_tone = 0; m_spk = 0; m_amp = 0;
  endtask

  // One rising edge of the reference: everything computed from values before the edge.
  task automatic model_step();
    int en, tgt, goal, nl, ns;
    bit ramping, tc;
    en      = int'(bus.enable_in);
    tgt     = (bus.enable_in && !bus.mute_in) ? int'(bus.volume_in) : 0;
    ramping = (m_state == S_ACT) || (m_state == S_DRN);
    tc      = ramping && ((m_ramp % RAMP) == RAMP - 1);
    nl      = m_level;
    if (tc) begin
      goal = (m_state == S_DRN) ? 0 : tgt;
      if (goal > m_level) nl = m_level + 1;
      else if (goal < m_level) nl = m_level - 1;
    end
    ns = m_state;
    case (m_state)
      S_OFF: ns = en ? S_WRM : S_OFF;
      S_WRM: if (!en) ns = S_OFF; else if (m_warm + 1 == WARM) ns = S_ACT;
      S_ACT: if (!en) ns = S_DRN;
      default: if (en) ns = S_ACT; else if (m_level == 0) ns = S_OFF;
    endcase
    m_spk   = (m_tone != 0 && m_pwm < m_level && m_state != S_OFF) ? 1 : 0;
    m_tone  = int'(bus.tone_in);
    m_pwm   = (m_state == S_OFF) ? 0 : (m_pwm + 1) % PERIOD;
    m_ramp  = ramping ? m_ramp + 1 : 0;
    m_warm  = (m_state == S_WRM) ? m_warm + 1 : 0;
    m_level = nl;
    m_state = ns;
    m_amp   = (ns != S_OFF) ? 1 : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("state", bus.state_out, m_state);
    chk("level", bus.level_out, m_level);
    chk("amp_sd_n", bus.amp_sd_n, m_amp);
    chk("speaker", bus.speaker_out, m_spk);
  endtask

  task automatic wait_level(input string tag, input int lvl, input int maxc, output int n);
    n = 0;
    while (bus.level_out !== PWM_BITS'(lvl) && n < maxc) begin
      cycle();
      n++;
    end
    chk(tag, bus.level_out, lvl);
  endtask

  initial begin
    int n, highs, hold;
    bus.enable_in = 1'b0;
    bus.tone_in   = 1'b0;
    bus.volume_in = '0;
    bus.mute_in   = 1'b0;
    model_reset();

    // reset takes effect before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst0_state", bus.state_out, S_OFF);
    chk("rst0_amp", bus.amp_sd_n, 0);
    chk("rst0_level", bus.level_out, 0);
    chk("rst0_spk", bus.speaker_out, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) cycle();

    // power-up ramp
    bus.enable_in = 1'b1; bus.volume_in = 4'd15; bus.tone_in = 1'b1;
    cycle();
    chk("pwr_amp", bus.amp_sd_n, 1);
    chk("pwr_state", bus.state_out, S_WRM);
    n = 1;
    while (bus.state_out == 2'(S_WRM) && n < 50) begin
      cycle();
      if (bus.state_out == 2'(S_WRM)) n++;
    end
    chk("warm_len", n, WARM);
    chk("after_warm", bus.state_out, S_ACT);
    n = 0;
    while (bus.level_out != 4'd15 && n < 200) begin cycle(); n++; end
    chk("ramp_len", n, 15 * RAMP);
    repeat (2) cycle();
    for (int i = 0; i < 15; i++) begin cycle(); chk("full_on", bus.speaker_out, 1); end

    // PWM duty at level 4, then a slow tone toggle
    bus.volume_in = 4'd4;
    wait_level("to_lvl4", 4, 100, n);
    repeat (3) cycle();
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin cycle(); highs += int'(bus.speaker_out); end
    chk("duty4", highs, 4);
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) bus.tone_in = ~bus.tone_in;
      cycle();
    end
    bus.tone_in = 1'b1;

    // fade-out from full level
    bus.volume_in = 4'd15;
    wait_level("to_lvl15", 15, 100, n);
    bus.enable_in = 1'b0;
    cycle();
    chk("drain_state", bus.state_out, S_DRN);
    wait_level("drain_14", 14, 10, n);
    wait_level("drain_0", 0, 100, n);
    chk("drain_len", n, 14 * RAMP);
    chk("drain_hold", bus.state_out, S_DRN);
    cycle();
    chk("off_state", bus.state_out, S_OFF);
    chk("off_amp", bus.amp_sd_n, 0);
    for (int i = 0; i < 5; i++) begin cycle(); chk("off_spk", bus.speaker_out, 0); end

    // re-enable while draining
    bus.enable_in = 1'b1;
    wait_level("re_up15", 15, 200, n);
    bus.enable_in = 1'b0;
    wait_level("re_dn7", 7, 100, n);
    bus.enable_in = 1'b1;
    cycle();
    chk("re_active", bus.state_out, S_ACT);
    wait_level("re_climb", 15, 100, n);
    chk("re_state", bus.state_out, S_ACT);

    // mute and volume change
    bus.mute_in = 1'b1;
    wait_level("mute_0", 0, 100, n);
    repeat (8) cycle();
    chk("mute_state", bus.state_out, S_ACT);
    chk("mute_amp", bus.amp_sd_n, 1);
    bus.mute_in = 1'b0; bus.volume_in = 4'd3;
    wait_level("unmute_3", 3, 50, n);
    repeat (20) cycle();
    chk("hold_3", bus.level_out, 3);

    // asynchronous reset mid-ramp
    bus.volume_in = 4'd15;
    wait_level("to_lvl9", 9, 100, n);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", bus.state_out, S_OFF);
    chk("rst_amp", bus.amp_sd_n, 0);
    chk("rst_level", bus.level_out, 0);
    chk("rst_spk", bus.speaker_out, 0);
    model_reset();
    bus.enable_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) cycle();
    chk("post_rst", bus.state_out, S_OFF);

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      bus.enable_in = ($urandom_range(0, 4) != 0);
      bus.mute_in   = ($urandom_range(0, 4) == 0);
      bus.volume_in = PWM_BITS'($urandom_range(0, PERIOD));
      hold = $urandom_range(1, 120);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 7) == 0) bus.tone_in = ~bus.tone_in;
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
